// File: rtl/crop_capture_ctrl_if.sv
// Bundles the trigger, measurement, frame-timing and capture-handshake
// signals of crop_capture_ctrl. "master" is the controller's view and
// "slave" is the view of the surrounding logic that drives the controller.
interface crop_capture_ctrl_if;
    logic        iSTART;
    logic        iFVAL;
    logic        iMEAS_DONE;
    logic [15:0] iMEAS_Y;
    logic        iCAP_ACK;
    logic        oMEAS_EN;
    logic        oCAP_REQ;
    logic [15:0] oWIN_Y0;
    logic [15:0] oWIN_Y1;
    logic        oBUSY;
    logic        oDONE;
    logic        oERR;

    modport master (
        input  iSTART, iFVAL, iMEAS_DONE, iMEAS_Y, iCAP_ACK,
        output oMEAS_EN, oCAP_REQ, oWIN_Y0, oWIN_Y1, oBUSY, oDONE, oERR
    );

    modport slave (
        output iSTART, iFVAL, iMEAS_DONE, iMEAS_Y, iCAP_ACK,
        input  oMEAS_EN, oCAP_REQ, oWIN_Y0, oWIN_Y1, oBUSY, oDONE, oERR
    );
endinterface

// File: rtl/crop_capture_ctrl.sv
// crop_capture_ctrl: runs NUM_MEAS Y-end measurements, reduces them to one
// value, derives a vertical crop window and supervises a one-frame capture.
// Build option CROP_AVG_EN: reduce by truncating mean instead of maximum.
module crop_capture_ctrl #(
    parameter int NUM_MEAS = 4,
    parameter int MARGIN   = 8,
    parameter int WIN_H    = 240,
    parameter int FRAME_H  = 480,
    parameter int TIMEOUT  = 8
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    crop_capture_ctrl_if.master  bus
);
    localparam int LOG2_N = $clog2(NUM_MEAS);
`ifdef CROP_AVG_EN
    localparam int ACC_W = 16 + LOG2_N;
`else
    localparam int ACC_W = 16;
`endif
    localparam int CNT_W = 5;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [16:0] Y_MAX    = 17'(FRAME_H - 1);
    localparam logic [15:0] WIN_SPAN = 16'(WIN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_MEAS, S_CALC, S_REQ, S_CAP, S_FIN
    } state_t;

    state_t             state_reg, state_next;
    logic               fval_prev_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [TMO_W-1:0]   tmo_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [15:0]        win_y0_reg, win_y1_reg;
    logic               err_reg;
    logic               cap_fs_reg;

    logic               frame_start, frame_end;
    logic [CNT_W-1:0]   cnt_inc;
    logic [TMO_W-1:0]   tmo_inc;
    logic [ACC_W-1:0]   acc_next;
    logic [15:0]        r_value;
    logic [16:0]        y1_sum;
    logic [15:0]        y1_value, y0_value;
    logic               run_start, take_sample, silent_fs;
    logic               load_win, set_err, cap_arm;

    assign frame_start = bus.iFVAL & ~fval_prev_reg;
    assign frame_end   = ~bus.iFVAL & fval_prev_reg;
    assign cnt_inc     = cnt_reg + CNT_W'(1);
    assign tmo_inc     = tmo_reg + TMO_W'(1);

`ifdef CROP_AVG_EN
    assign acc_next = acc_reg + ACC_W'(bus.iMEAS_Y);
    assign r_value  = 16'(acc_reg >> LOG2_N);
`else
    assign acc_next = (bus.iMEAS_Y > acc_reg) ? bus.iMEAS_Y : acc_reg;
    assign r_value  = acc_reg;
`endif

    // Window arithmetic: the margin add is done in 17 bits so a large
    // Y-end clamps to the last frame line instead of wrapping.
    assign y1_sum   = {1'b0, r_value} + 17'(MARGIN);
    assign y1_value = (y1_sum > Y_MAX) ? Y_MAX[15:0] : y1_sum[15:0];
    assign y0_value = (y1_value >= WIN_SPAN) ? (y1_value - WIN_SPAN) : 16'd0;

    // State register; reset withdraws any run immediately.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus single-cycle strobes for the datapath.
    always_comb begin
        state_next  = state_reg;
        run_start   = 1'b0;
        take_sample = 1'b0;
        silent_fs   = 1'b0;
        load_win    = 1'b0;
        set_err     = 1'b0;
        cap_arm     = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (bus.iSTART) begin
                    run_start  = 1'b1;
                    state_next = S_SYNC;
                end
            end
            S_SYNC: begin
                if (frame_start) state_next = S_MEAS;
            end
            S_MEAS: begin
                // A result coinciding with a frame start counts as a result,
                // so it takes priority over the silent-frame count.
                if (bus.iMEAS_DONE) begin
                    take_sample = 1'b1;
                    if (cnt_inc == CNT_W'(NUM_MEAS)) state_next = S_CALC;
                end else if (frame_start) begin
                    silent_fs = 1'b1;
                    if (tmo_inc == TMO_W'(TIMEOUT)) begin
                        set_err    = 1'b1;
                        state_next = S_FIN;
                    end
                end
            end
            S_CALC: begin
                if (r_value == 16'd0) begin
                    set_err    = 1'b1;
                    state_next = S_FIN;
                end else begin
                    load_win   = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.iCAP_ACK) state_next = S_CAP;
            end
            S_CAP: begin
                // Only a frame end that follows a frame start inside CAP
                // closes a complete captured frame.
                if (frame_start) cap_arm = 1'b1;
                else if (frame_end && cap_fs_reg) state_next = S_FIN;
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Frame-edge history, counters, accumulator, window and error flag.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fval_prev_reg <= 1'b0;
            cnt_reg       <= '0;
            tmo_reg       <= '0;
            acc_reg       <= '0;
            win_y0_reg    <= '0;
            win_y1_reg    <= '0;
            err_reg       <= 1'b0;
            cap_fs_reg    <= 1'b0;
        end else begin
            fval_prev_reg <= bus.iFVAL;
            if (run_start) begin
                cnt_reg    <= '0;
                tmo_reg    <= '0;
                acc_reg    <= '0;
                err_reg    <= 1'b0;
                cap_fs_reg <= 1'b0;
            end
            if (take_sample) begin
                acc_reg <= acc_next;
                cnt_reg <= cnt_inc;
                tmo_reg <= '0;
            end else if (silent_fs) begin
                tmo_reg <= tmo_inc;
            end
            if (cap_arm) cap_fs_reg <= 1'b1;
            if (load_win) begin
                win_y0_reg <= y0_value;
                win_y1_reg <= y1_value;
            end
            if (set_err) err_reg <= 1'b1;
        end
    end

    assign bus.oMEAS_EN = (state_reg == S_MEAS);
    assign bus.oCAP_REQ = (state_reg == S_REQ);
    assign bus.oBUSY    = (state_reg != S_IDLE);
    assign bus.oDONE    = (state_reg == S_FIN);
    assign bus.oERR     = err_reg;
    assign bus.oWIN_Y0  = win_y0_reg;
    assign bus.oWIN_Y1  = win_y1_reg;
endmodule
